// File: rtl/necpu_pkg.sv
// Shared types and constants for the NECPU fetch path.
package necpu_pkg;

  localparam int unsigned INST_W = 32;

  localparam int unsigned DEFAULT_RESET_PC = 0;

  // RUN fetches freely, HALT blocks fetches, STEP allows exactly one fetch.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/necpu_fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs between instMem and decode.
// Head is combinational and reads zero when empty; flush beats push and pop.
module necpu_fetch_fifo
  import necpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_idx]   <= push_pc;
      inst_mem[wr_idx] <= push_inst;
    end
  end

  always_comb begin
    head_pc   = '0;
    head_inst = '0;
    if (!empty) begin
      head_pc   = pc_mem[rd_idx];
      head_inst = inst_mem[rd_idx];
    end
  end

endmodule

// File: rtl/necpu_fetch_ctrl.sv
// NECPU instruction-fetch sequencer: PC register, prefetch FIFO and decode handshake.
// Optional debug halt/step control is built when NECPU_FETCH_STEP_EN is defined.
module necpu_fetch_ctrl
  import necpu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
`ifdef NECPU_FETCH_STEP_EN
  ,
  input  logic              dbg_halt,
  input  logic              dbg_step,
  output logic              halted
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              permit;

  assign if_valid  = !fifo_empty;
  assign pop       = if_valid && if_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = enable && permit && !redirect_valid && (!fifo_full || pop);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_ONE;
    end
  end

  necpu_fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (fetch_pc),
    .push_inst (imem_inst),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );

`ifdef NECPU_FETCH_STEP_EN
  fetch_state_e state;

  assign permit = (state != HALT);

  // A redirect freezes the FSM so a pending step survives the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (!redirect_valid) begin
      unique case (state)
        RUN: begin
          if (dbg_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (dbg_step) begin
            state  <= STEP;
            halted <= 1'b0;
          end else if (!dbg_halt) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        STEP: begin
          if (push) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end
`else
  assign permit = 1'b1;
`endif

endmodule
